top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on rising clk).
REQ-003 m1_U_start  input  1  master-1 transaction request, level.
REQ-004 m1_U_addr  input  16  master-1 target address.
REQ-005 m1_U_wdata  input  8  master-1 write data.
REQ-006 m1_U_mode  input  1  master-1 direction: 0 read, 1 write.
REQ-007 m1_state_show  output  3  master-1 FSM state code.
REQ-008 m1_U_rdata  output  8  master-1 last read data, registered.
REQ-009 m2_U_start, m2_U_addr[15:0], m2_U_wdata[7:0], m2_U_mode, m2_state_show[2:0], m2_U_rdata[7:0]: same directions, widths and meanings as master-1, for master 2.

Function
REQ-010 top SHALL contain two identical master controllers, one shared bus, one arbiter, one address decoder and three slave memories.
REQ-011 Master FSM codes: IDLE=0, REQ=1, ADDR=2, WRITE=3, READ=4, DONE=5; state_show SHALL equal the current code; codes 6-7 unused and SHALL return to IDLE.
REQ-012 IDLE: U_start=1 -> latch U_addr, U_wdata, U_mode, go REQ; otherwise stay.
REQ-013 REQ: assert bus request; go ADDR on the edge where registered grant is 1 for this master.
REQ-014 ADDR: drive latched address onto bus; next state WRITE if mode=1, else READ.
REQ-015 WRITE: drive latched wdata with write strobe; selected slave commits the byte at the edge leaving WRITE; go DONE.
REQ-016 READ: selected slave drives read data combinationally; master loads U_rdata at the edge leaving READ; go DONE.
REQ-017 DONE: request deasserted; stay while U_start=1; go IDLE when U_start=0 (one transaction per start pulse, no auto-repeat).
REQ-018 Inputs changing after the IDLE latch edge SHALL NOT affect the in-flight transaction.
REQ-019 Arbiter: registered grant; when bus free and any request asserted, grant at next edge; master 1 wins simultaneous requests.
REQ-020 Arbiter non-preemptive: owner keeps grant until its request drops (DONE entry); grant then cleared at next edge and bus re-arbitrated.
REQ-021 Latency with free bus: start sampled at edge 0 -> REQ at 1, grant at 2, ADDR at 3, WRITE/READ at 4, DONE at 5; write commit / U_rdata update at edge 5.
REQ-022 Decoder: addr[15:12]=1,2,3 selects slave 1,2,3; addr[7:0] is byte offset in a 256x8 memory; addr[11:8] ignored (aliases).
REQ-023 Unmapped addr[15:12] (0, 4-F): write discarded, read returns 0x00, transaction still completes normally.
REQ-024 Bus mux SHALL route only the granted master's address, data, mode and strobe; non-granted master has no slave effect.
REQ-025 U_rdata SHALL hold its value until the next read by that master completes.

Reset
REQ-026 rst_n=1 at an edge: both FSMs IDLE (state_show=0), U_rdata=0x00 on both masters, grant cleared, latched registers cleared.
REQ-027 Reset mid-transaction SHALL abort it without a memory write; slave memory contents are not reset and SHALL be retained.
REQ-028 After reset release, a master whose U_start is still 1 SHALL start a new transaction from IDLE.

Verification
REQ-029 Reset, m1 write 0x55 to 0x1001 alone -> m1_state_show 0,1,1,2,3,5; slave1[0x01]=0x55 at edge 5.
REQ-030 m1 write 0x55@0x1001, m2 write 0xAA@0x2001 starting one cycle later -> m1 completes first; m2 holds REQ until m1 reaches DONE, then writes slave2[0x01]=0xAA.
REQ-031 Then m1 read 0x1001 -> m1_U_rdata=0x55 on DONE entry; m2 read 0x2001 -> m2_U_rdata=0xAA.
REQ-032 Both masters start on the same edge -> m1 granted first; m2 enters ADDR only after m1 releases.
REQ-033 m1 read 0x5000 (unmapped) -> m1_U_rdata=0x00, FSM reaches DONE; write to 0x5000 alters no slave.
REQ-034 rst_n=1 while m1 in WRITE -> state_show=0, U_rdata=0x00, target byte unchanged; previously written 0x55@0x1001 still readable.

Source files
------------

// File: rtl/top.sv
// Two-master shared-bus system: two identical master controllers, a
// registered non-preemptive arbiter, an address decoder and three
// 256x8 slave memories. rst_n is an active-high synchronous reset.
`timescale 1ns/1ps

// Master controller: latches a request in IDLE, wins the bus, then performs
// a single read or write and parks in DONE until start drops.
module top_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        mode,
  input  logic        gnt,
  input  logic [7:0]  bus_rdata,
  output logic        req,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic [2:0]  state_show,
  output logic [7:0]  rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ADDR  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        mode_q, mode_d;
  logic [7:0]  rdata_q, rdata_d;

  assign state_show = state_q;
  assign rdata      = rdata_q;

  // Next-state, request and bus-drive decode; bus outputs are zero unless driving.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mode_d    = mode_q;
    rdata_d   = rdata_q;
    req       = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          mode_d  = mode;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (gnt) state_d = S_ADDR;
      end
      S_ADDR: begin
        req      = 1'b1;
        bus_addr = addr_q;
        state_d  = mode_q ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        req       = 1'b1;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_we    = 1'b1;
        state_d   = S_DONE;
      end
      S_READ: begin
        req      = 1'b1;
        bus_addr = addr_q;
        rdata_d  = bus_rdata;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// Arbiter: registered owner; master 1 wins ties; owner keeps the bus until
// its request drops, then the bus passes through a free cycle.
module top_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;

  assign gnt1 = (owner_q == OWN_M1);
  assign gnt2 = (owner_q == OWN_M2);

  // Grant selection: arbitrate only from the free state.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (req1)      owner_d = OWN_M1;
        else if (req2) owner_d = OWN_M2;
      end
      OWN_M1:  if (!req1) owner_d = OWN_NONE;
      OWN_M2:  if (!req2) owner_d = OWN_NONE;
      default: owner_d = OWN_NONE;
    endcase
  end

  // Owner register.
  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

endmodule

// Slave memory: 256x8, combinational read, write on the clock edge.
// Contents are deliberately not reset.
module top_slave (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [256];

  assign rdata = mem_q[addr];

  // Byte write.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

endmodule

module top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m1_U_start,
  input  logic [15:0] m1_U_addr,
  input  logic [7:0]  m1_U_wdata,
  input  logic        m1_U_mode,
  output logic [2:0]  m1_state_show,
  output logic [7:0]  m1_U_rdata,
  input  logic        m2_U_start,
  input  logic [15:0] m2_U_addr,
  input  logic [7:0]  m2_U_wdata,
  input  logic        m2_U_mode,
  output logic [2:0]  m2_state_show,
  output logic [7:0]  m2_U_rdata
);

  logic        req1, req2, gnt1, gnt2;
  logic [15:0] m1_baddr, m2_baddr, bus_addr;
  logic [7:0]  m1_bwdata, m2_bwdata, bus_wdata;
  logic        m1_bwe, m2_bwe, bus_we;
  logic [7:0]  bus_rdata;
  logic [7:0]  s1_rdata, s2_rdata, s3_rdata;
  logic        we1, we2, we3;
  logic        unused_alias;

  top_master u_m1 (
    .clk(clk), .rst(rst_n), .start(m1_U_start), .addr(m1_U_addr),
    .wdata(m1_U_wdata), .mode(m1_U_mode), .gnt(gnt1), .bus_rdata(bus_rdata),
    .req(req1), .bus_addr(m1_baddr), .bus_wdata(m1_bwdata), .bus_we(m1_bwe),
    .state_show(m1_state_show), .rdata(m1_U_rdata)
  );

  top_master u_m2 (
    .clk(clk), .rst(rst_n), .start(m2_U_start), .addr(m2_U_addr),
    .wdata(m2_U_wdata), .mode(m2_U_mode), .gnt(gnt2), .bus_rdata(bus_rdata),
    .req(req2), .bus_addr(m2_baddr), .bus_wdata(m2_bwdata), .bus_we(m2_bwe),
    .state_show(m2_state_show), .rdata(m2_U_rdata)
  );

  top_arbiter u_arb (
    .clk(clk), .rst(rst_n), .req1(req1), .req2(req2), .gnt1(gnt1), .gnt2(gnt2)
  );

  // Bus mux: only the granted master reaches the slaves.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (gnt1) begin
      bus_addr  = m1_baddr;
      bus_wdata = m1_bwdata;
      bus_we    = m1_bwe;
    end else if (gnt2) begin
      bus_addr  = m2_baddr;
      bus_wdata = m2_bwdata;
      bus_we    = m2_bwe;
    end
  end

  // Address bits 11:8 alias within each slave window.
  assign unused_alias = ^bus_addr[11:8];

  // Decoder: write strobes per slave (suppressed under reset so an aborted
  // WRITE never commits) and read-data select; unmapped reads return zero.
  always_comb begin
    we1       = 1'b0;
    we2       = 1'b0;
    we3       = 1'b0;
    bus_rdata = '0;
    case (bus_addr[15:12])
      4'h1: begin we1 = bus_we & ~rst_n; bus_rdata = s1_rdata; end
      4'h2: begin we2 = bus_we & ~rst_n; bus_rdata = s2_rdata; end
      4'h3: begin we3 = bus_we & ~rst_n; bus_rdata = s3_rdata; end
      default: bus_rdata = '0;
    endcase
  end

  top_slave u_s1 (.clk(clk), .we(we1), .addr(bus_addr[7:0]), .wdata(bus_wdata), .rdata(s1_rdata));
  top_slave u_s2 (.clk(clk), .we(we2), .addr(bus_addr[7:0]), .wdata(bus_wdata), .rdata(s2_rdata));
  top_slave u_s3 (.clk(clk), .we(we3), .addr(bus_addr[7:0]), .wdata(bus_wdata), .rdata(s3_rdata));

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the two-master shared-bus system.
`timescale 1ns/1ps

module tb_top;

  logic        clk;
  logic        rst_n;
  logic        m1_start, m2_start;
  logic [15:0] m1_addr, m2_addr;
  logic [7:0]  m1_wdata, m2_wdata;
  logic        m1_mode, m2_mode;
  logic [2:0]  m1_state, m2_state;
  logic [7:0]  m1_rdata, m2_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         m;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[int];

  top dut (
    .clk(clk), .rst_n(rst_n),
    .m1_U_start(m1_start), .m1_U_addr(m1_addr), .m1_U_wdata(m1_wdata),
    .m1_U_mode(m1_mode), .m1_state_show(m1_state), .m1_U_rdata(m1_rdata),
    .m2_U_start(m2_start), .m2_U_addr(m2_addr), .m2_U_wdata(m2_wdata),
    .m2_U_mode(m2_mode), .m2_state_show(m2_state), .m2_U_rdata(m2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] st(input int m);
    return (m == 1) ? m1_state : m2_state;
  endfunction

  function automatic logic [7:0] rd(input int m);
    return (m == 1) ? m1_rdata : m2_rdata;
  endfunction

  task automatic set_in(input int m, input logic [15:0] a, input logic [7:0] d, input logic wr);
    if (m == 1) begin m1_addr = a; m1_wdata = d; m1_mode = wr; end
    else        begin m2_addr = a; m2_wdata = d; m2_mode = wr; end
  endtask

  task automatic set_start(input int m, input logic v);
    if (m == 1) m1_start = v;
    else        m2_start = v;
  endtask

  function automatic int key(input logic [15:0] a);
    return int'(a[15:12]) * 256 + int'(a[7:0]);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (a[15:12] >= 4'h1 && a[15:12] <= 4'h3) model[key(a)] = d;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a[15:12] >= 4'h1 && a[15:12] <= 4'h3 && model.exists(key(a))) return model[key(a)];
    return 8'h00;
  endfunction

  // Drive one transaction until the master reports DONE (start left high).
  task automatic run_txn(input int m, input logic [15:0] a, input logic [7:0] d,
                         input logic wr, input bit scramble, output bit to);
    to = 1'b1;
    set_in(m, a, d, wr);
    set_start(m, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0 && scramble) set_in(m, 16'h1001, 8'h66, 1'b1);
      if (st(m) == 3'd5) begin to = 1'b0; break; end
    end
  endtask

  task automatic release_txn(input int m);
    set_start(m, 1'b0);
    tick();
  endtask

  // Run both masters concurrently, recording when each reaches ADDR and DONE.
  task automatic run_dual(input int m2_delay, output int a1, output int d1,
                          output int a2, output int d2, output logic [7:0] r1,
                          output logic [7:0] r2, output bit held, output bit to);
    a1 = -1; d1 = -1; a2 = -1; d2 = -1; r1 = '0; r2 = '0; held = 1'b1; to = 1'b1;
    m1_start = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == m2_delay) m2_start = 1'b1;
      tick();
      if (a1 < 0 && m1_state == 3'd2) a1 = cyc;
      if (d1 < 0 && m1_state == 3'd5) begin d1 = cyc; r1 = m1_rdata; m1_start = 1'b0; end
      if (a2 < 0 && m2_state == 3'd2) a2 = cyc;
      if (d2 < 0 && m2_state == 3'd5) begin d2 = cyc; r2 = m2_rdata; m2_start = 1'b0; end
      if (d1 < 0 && m2_state != 3'd0 && m2_state != 3'd1) held = 1'b0;
      if (d1 >= 0 && d2 >= 0 && m1_state == 3'd0 && m2_state == 3'd0) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    int exp_st[$];
    rst_n = 1'b1;
    m1_start = 1'b1; m1_addr = 16'h1001; m1_wdata = 8'h55; m1_mode = 1'b1;
    m2_start = 1'b0; m2_addr = '0;       m2_wdata = '0;    m2_mode = 1'b0;
    tick();
    checks++; if (m1_state !== 3'd0) begin errors++; $display("FAIL reset_m1_state: got %0d expected 0", m1_state); end
    checks++; if (m2_state !== 3'd0) begin errors++; $display("FAIL reset_m2_state: got %0d expected 0", m2_state); end
    checks++; if (m1_rdata !== 8'h00) begin errors++; $display("FAIL reset_m1_rdata: got %02h expected 00", m1_rdata); end
    checks++; if (m2_rdata !== 8'h00) begin errors++; $display("FAIL reset_m2_rdata: got %02h expected 00", m2_rdata); end
    rst_n = 1'b0;
    exp_st = '{1, 1, 2, 3, 5};
    model_write(16'h1001, 8'h55);
    for (int i = 1; i <= 5; i++) begin
      int e;
      tick();
      e = exp_st.pop_front();
      checks++;
      if (m1_state !== 3'(e)) begin errors++; $display("FAIL write_seq_edge%0d: got %0d expected %0d", i, m1_state, e); end
    end
    release_txn(1);
    checks++; if (m1_state !== 3'd0) begin errors++; $display("FAIL done_to_idle: got %0d expected 0", m1_state); end
  endtask

  task automatic test_contention();
    int a1, d1, a2, d2;
    logic [7:0] r1, r2;
    bit held, to;
    set_in(1, 16'h1001, 8'h55, 1'b1);
    set_in(2, 16'h2001, 8'hAA, 1'b1);
    model_write(16'h1001, 8'h55);
    model_write(16'h2001, 8'hAA);
    run_dual(1, a1, d1, a2, d2, r1, r2, held, to);
    checks++; if (to) begin errors++; $display("FAIL contention_timeout: got timeout expected completion"); end
    checks++; if (!(d1 >= 0 && a2 > d1)) begin errors++; $display("FAIL contention_order: got m2 ADDR cycle %0d expected after m1 DONE cycle %0d", a2, d1); end
    checks++; if (!held) begin errors++; $display("FAIL contention_m2_held: got m2 left REQ early expected REQ until m1 DONE"); end
  endtask

  task automatic test_read_back();
    logic [15:0] ra[3];
    int          rm[3];
    bit          to;
    exp_t        e;
    ra = '{16'h1001, 16'h2001, 16'h1F01};
    rm = '{1, 2, 1};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{m: rm[i], data: model_read(ra[i])});
      run_txn(rm[i], ra[i], 8'h00, 1'b0, 1'b0, to);
      e = sb.pop_front();
      checks++;
      if (to || rd(e.m) !== e.data) begin
        errors++; $display("FAIL read_back_%04h: got %02h expected %02h (timeout=%0d)", ra[i], rd(e.m), e.data, to);
      end
      release_txn(rm[i]);
    end
  endtask

  task automatic test_simultaneous();
    int a1, d1, a2, d2;
    logic [7:0] r1, r2;
    bit held, to;
    exp_t e;
    set_in(1, 16'h2001, 8'h00, 1'b0);
    set_in(2, 16'h1001, 8'h00, 1'b0);
    sb.push_back('{m: 1, data: model_read(16'h2001)});
    sb.push_back('{m: 2, data: model_read(16'h1001)});
    run_dual(0, a1, d1, a2, d2, r1, r2, held, to);
    checks++; if (to) begin errors++; $display("FAIL simul_timeout: got timeout expected completion"); end
    checks++; if (!(a1 >= 0 && d1 >= 0 && a2 > d1)) begin errors++; $display("FAIL simul_order: got m1 ADDR %0d DONE %0d m2 ADDR %0d expected m2 ADDR after m1 DONE", a1, d1, a2); end
    e = sb.pop_front();
    checks++; if (r1 !== e.data) begin errors++; $display("FAIL simul_m1_rdata: got %02h expected %02h", r1, e.data); end
    e = sb.pop_front();
    checks++; if (r2 !== e.data) begin errors++; $display("FAIL simul_m2_rdata: got %02h expected %02h", r2, e.data); end
  endtask

  task automatic test_unmapped();
    logic [15:0] wa[6];
    logic [7:0]  wd[6];
    logic [15:0] ra[5];
    bit          to;
    exp_t        e;
    wa = '{16'h1000, 16'h2000, 16'h3000, 16'h5000, 16'h0000, 16'hF000};
    wd = '{8'h11,    8'h22,    8'h33,    8'hEE,    8'hEE,    8'hEE};
    for (int i = 0; i < 6; i++) begin
      model_write(wa[i], wd[i]);
      run_txn(2, wa[i], wd[i], 1'b1, 1'b0, to);
      checks++; if (to) begin errors++; $display("FAIL unmapped_write_%04h: got timeout expected DONE", wa[i]); end
      release_txn(2);
    end
    ra = '{16'h5000, 16'h1000, 16'h2000, 16'h3000, 16'hA0FF};
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{m: 1, data: model_read(ra[i])});
      run_txn(1, ra[i], 8'h00, 1'b0, 1'b0, to);
      e = sb.pop_front();
      checks++;
      if (to || m1_rdata !== e.data) begin
        errors++; $display("FAIL unmapped_read_%04h: got %02h expected %02h (timeout=%0d)", ra[i], m1_rdata, e.data, to);
      end
      release_txn(1);
    end
  endtask

  task automatic test_input_hold();
    bit   to;
    exp_t e;
    // Inputs scrambled to a write of 0x66@0x1001 right after the latch edge.
    sb.push_back('{m: 1, data: model_read(16'h2001)});
    run_txn(1, 16'h2001, 8'h00, 1'b0, 1'b1, to);
    e = sb.pop_front();
    checks++; if (to || m1_rdata !== e.data) begin errors++; $display("FAIL latched_inputs: got %02h expected %02h", m1_rdata, e.data); end
    release_txn(1);
    model_write(16'h3005, 8'h77);
    run_txn(1, 16'h3005, 8'h77, 1'b1, 1'b0, to);
    checks++; if (to || m1_rdata !== e.data) begin errors++; $display("FAIL rdata_hold: got %02h expected %02h", m1_rdata, e.data); end
    release_txn(1);
    sb.push_back('{m: 1, data: model_read(16'h1001)});
    run_txn(1, 16'h1001, 8'h00, 1'b0, 1'b0, to);
    e = sb.pop_front();
    checks++; if (to || m1_rdata !== e.data) begin errors++; $display("FAIL no_stray_write: got %02h expected %02h", m1_rdata, e.data); end
    release_txn(1);
  endtask

  task automatic test_reset_mid();
    bit   hit;
    exp_t e;
    hit = 1'b0;
    set_in(1, 16'h1001, 8'h99, 1'b1);
    m1_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m1_state == 3'd3) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL reset_mid_reach_write: got state %0d expected 3", m1_state); end
    rst_n = 1'b1;
    set_in(1, 16'h1001, 8'h00, 1'b0);
    tick();
    checks++; if (m1_state !== 3'd0) begin errors++; $display("FAIL reset_mid_state: got %0d expected 0", m1_state); end
    checks++; if (m1_rdata !== 8'h00) begin errors++; $display("FAIL reset_mid_rdata: got %02h expected 00", m1_rdata); end
    rst_n = 1'b0;
    tick();
    checks++; if (m1_state !== 3'd1) begin errors++; $display("FAIL restart_after_reset: got %0d expected 1", m1_state); end
    sb.push_back('{m: 1, data: model_read(16'h1001)});
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m1_state == 3'd5) begin hit = 1'b1; break; end
    end
    e = sb.pop_front();
    checks++; if (!hit || m1_rdata !== e.data) begin errors++; $display("FAIL reset_retains_mem: got %02h expected %02h (done=%0d)", m1_rdata, e.data, hit); end
    release_txn(1);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_read_back();
    test_simultaneous();
    test_unmapped();
    test_input_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
